// File: rtl/ccu_ctrl_wr_snoop_gen.sv
// ---------------------------------------------------------------------------
// ccu_ctrl_wr_snoop_gen
//
// Purpose: write-side controller of a cache-coherent interconnect. A write
// from a cached ACE master is first turned into a snoop (AC) towards the
// other caches. Depending on the snoop response (CR) the controller either
// writes the returned dirty line back to memory (CD -> WRAP burst), discards
// the line data (snoop reported an error), or goes straight to the original
// write. The original write is then replayed to memory, and its B response
// is returned to the master. A failed write-back is reported on that final
// B as SLVERR. Non-snooping writes can bypass the snoop phase.
// Only one transaction is in flight at a time.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   slv_req_i     ACE request from the cached master (AW/W/B ready used)
//   snoop_trs_i   decoded AC snoop opcode for the AW currently presented
//   slv_resp_o    response to the cached master (AW/W ready, B)
//   mst_req_o     AXI request to memory (AW/W, B ready)
//   mst_resp_i    AXI response from memory (AW/W ready, B)
//   snoop_req_o   AC request plus CR/CD ready towards the snoop crossbar
//   snoop_resp_i  AC ready, CR response and CD data from the snoop crossbar
//
// The package below supplies the default channel types so the block
// elaborates stand-alone; integrations pass their own struct types.
// ---------------------------------------------------------------------------
package ccu_ctrl_wr_snoop_gen_pkg;
  typedef logic [3:0] acsnoop_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [2:0]  snoop;
    logic [1:0]  domain;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
    logic     rack;
    logic     wack;
  } slv_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } slv_resp_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } mst_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } mst_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    acsnoop_t    snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;
endpackage

module ccu_ctrl_wr_snoop_gen #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned CachelineBeats = 4,
  parameter bit          BypassNoSnoop  = 1'b1,
  parameter type slv_req_t        = ccu_ctrl_wr_snoop_gen_pkg::slv_req_t,
  parameter type slv_resp_t       = ccu_ctrl_wr_snoop_gen_pkg::slv_resp_t,
  parameter type mst_req_t        = ccu_ctrl_wr_snoop_gen_pkg::mst_req_t,
  parameter type mst_resp_t       = ccu_ctrl_wr_snoop_gen_pkg::mst_resp_t,
  parameter type slv_aw_chan_t    = ccu_ctrl_wr_snoop_gen_pkg::aw_chan_t,
  parameter type mst_snoop_req_t  = ccu_ctrl_wr_snoop_gen_pkg::snoop_req_t,
  parameter type mst_snoop_resp_t = ccu_ctrl_wr_snoop_gen_pkg::snoop_resp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  slv_req_t                            slv_req_i,
  input  ccu_ctrl_wr_snoop_gen_pkg::acsnoop_t snoop_trs_i,
  output slv_resp_t                           slv_resp_o,
  output mst_req_t                            mst_req_o,
  input  mst_resp_t                           mst_resp_i,
  output mst_snoop_req_t                      snoop_req_o,
  input  mst_snoop_resp_t                     snoop_resp_i
);

  localparam int unsigned CntW   = $clog2(CachelineBeats) + 1;
  localparam logic [CntW-1:0] Beats   = CntW'(CachelineBeats);
  localparam logic [CntW-1:0] LastIdx = CntW'(CachelineBeats - 1);
  localparam logic [2:0] BeatSize = 3'($clog2(DataWidth / 8));

  typedef enum logic [2:0] {
    IDLE,
    SNP_RESP,
    WB,
    WB_B,
    DRAIN,
    WR,
    WR_B
  } state_e;

  state_e                              state_q, state_d;
  slv_aw_chan_t                        holder_q, holder_d;
  ccu_ctrl_wr_snoop_gen_pkg::acsnoop_t snp_q, snp_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic                                wb_err_q, wb_err_d;
  logic                                aw_valid_q, aw_valid_d;
  logic                                aw_done_q, aw_done_d;
  logic                                w_done_q, w_done_d;

  logic aw_hs;
  logic w_last_hs;
  logic bypass;

  always_comb begin
    state_d    = state_q;
    holder_d   = holder_q;
    snp_d      = snp_q;
    cnt_d      = cnt_q;
    wb_err_d   = wb_err_q;
    aw_valid_d = aw_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    w_last_hs  = 1'b0;

    slv_resp_o  = '0;
    mst_req_o   = '0;
    snoop_req_o = '0;

    // The memory AW is owned by a register so it cannot drop before its
    // handshake, whatever the state logic does in the meantime.
    mst_req_o.aw_valid = aw_valid_q;
    mst_req_o.aw       = holder_q;
    aw_hs              = aw_valid_q & mst_resp_i.aw_ready;
    if (aw_hs) begin
      aw_valid_d = 1'b0;
      aw_done_d  = 1'b1;
    end

    snoop_req_o.ac.addr  = slv_req_i.aw.addr;
    snoop_req_o.ac.prot  = slv_req_i.aw.prot;
    snoop_req_o.ac.snoop = snoop_trs_i;

    bypass = BypassNoSnoop && (slv_req_i.aw.snoop == 3'b000);

    unique case (state_q)
      IDLE: begin
        if (bypass) begin
          slv_resp_o.aw_ready = 1'b1;
          if (slv_req_i.aw_valid) begin
            holder_d   = slv_req_i.aw;
            snp_d      = snoop_trs_i;
            aw_valid_d = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = WR;
          end
        end else begin
          snoop_req_o.ac_valid = slv_req_i.aw_valid;
          slv_resp_o.aw_ready  = snoop_resp_i.ac_ready;
          if (slv_req_i.aw_valid && snoop_resp_i.ac_ready) begin
            holder_d = slv_req_i.aw;
            snp_d    = snoop_trs_i;
            state_d  = SNP_RESP;
          end
        end
      end

      SNP_RESP: begin
        snoop_req_o.cr_ready = 1'b1;
        if (snoop_resp_i.cr_valid) begin
          // cr_resp[0] = DataTransfer, cr_resp[1] = Error
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (snoop_resp_i.cr_resp[0] && !snoop_resp_i.cr_resp[1]) begin
            aw_valid_d = 1'b1;
            state_d    = WB;
          end else if (snoop_resp_i.cr_resp[0]) begin
            state_d = DRAIN;
          end else begin
            aw_valid_d = 1'b1;
            state_d    = WR;
          end
        end
      end

      WB: begin
        mst_req_o.aw.burst = 2'b10;
        mst_req_o.aw.len   = 8'(CachelineBeats - 1);
        mst_req_o.aw.size  = BeatSize;
        mst_req_o.w.data   = snoop_resp_i.cd.data;
        mst_req_o.w.strb   = '1;
        // CD's own last flag is not trusted; the beat count frames the burst.
        mst_req_o.w.last   = (cnt_q == LastIdx);
        if (cnt_q < Beats) begin
          mst_req_o.w_valid    = snoop_resp_i.cd_valid;
          snoop_req_o.cd_ready = mst_resp_i.w_ready;
          if (snoop_resp_i.cd_valid && mst_resp_i.w_ready) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if ((cnt_d == Beats) && (aw_done_q || aw_hs)) begin
          aw_done_d = 1'b0;
          state_d   = WB_B;
        end
      end

      WB_B: begin
        mst_req_o.b_ready = 1'b1;
        if (mst_resp_i.b_valid) begin
          wb_err_d   = mst_resp_i.b.resp[1];
          aw_valid_d = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = WR;
        end
      end

      DRAIN: begin
        snoop_req_o.cd_ready = 1'b1;
        if (snoop_resp_i.cd_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            aw_valid_d = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = WR;
          end
        end
      end

      WR: begin
        mst_req_o.w         = slv_req_i.w;
        mst_req_o.w_valid   = slv_req_i.w_valid & ~w_done_q;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & ~w_done_q;
        w_last_hs = slv_req_i.w_valid & mst_resp_i.w_ready & ~w_done_q & slv_req_i.w.last;
        if (w_last_hs) begin
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end

      WR_B: begin
        slv_resp_o.b_valid = mst_resp_i.b_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        slv_resp_o.b.id    = mst_resp_i.b.id;
        // A failed write-back overrides an otherwise successful final write.
        if (wb_err_q && !mst_resp_i.b.resp[1]) begin
          slv_resp_o.b.resp = 2'b10;
        end else begin
          slv_resp_o.b.resp = mst_resp_i.b.resp;
        end
        if (mst_resp_i.b_valid && slv_req_i.b_ready) begin
          wb_err_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      holder_q   <= '0;
      snp_q      <= '0;
      cnt_q      <= '0;
      wb_err_q   <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      holder_q   <= holder_d;
      snp_q      <= snp_d;
      cnt_q      <= cnt_d;
      wb_err_q   <= wb_err_d;
      aw_valid_q <= aw_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read channels and the remaining response bits are not handled here.
  logic unused_inputs;
  assign unused_inputs = ^{slv_req_i.ar, slv_req_i.ar_valid, slv_req_i.r_ready,
                           slv_req_i.rack, slv_req_i.wack, mst_resp_i.ar_ready,
                           mst_resp_i.r_valid, mst_resp_i.r,
                           snoop_resp_i.cr_resp[4:2], snoop_resp_i.cd.last, snp_q};

endmodule
